// File: rtl/mvb_frame_serializer.sv
// ---------------------------------------------------------------------------
// mvb_frame_serializer
//
// Converts a frame of word_count parallel words into a contiguous serial bit
// stream. A one-word holding register sits in front of the shift register.
// The next word can therefore be accepted while the current one is shifting,
// which lets back-to-back words leave without a gap. If no word is ready when
// the last bit of a word is sent and more words remain, the frame is dropped
// and underrun pulses.
//
// Ports
//   clk_1d5M    single rising-edge clock
//   reset       asynchronous, active-high reset
//   start       frame request, sampled only while idle
//   word_count  number of words in the frame, sampled with start (0 = ignored)
//   abort       synchronous frame cancel, ignored while idle
//   data_in     parallel word
//   data_valid  data_in is valid
//   data_ready  block accepts data_in this cycle
//   dout        serial bit, forced to 0 whenever dout_en is 0
//   dout_en     dout carries a frame bit
//   busy        a frame is in progress
//   done        one-cycle pulse in the cycle after the final bit
//   underrun    one-cycle pulse when the frame is dropped for lack of data
// ---------------------------------------------------------------------------
module mvb_frame_serializer #(
   parameter int DATA_W    = 16,
   parameter int CNT_W     = 5,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk_1d5M,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              abort,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              dout,
   output logic              dout_en,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_FIRST, SHIFT, FINISH} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;        // words in this frame
   logic [CNT_W-1:0]    accepted_q, accepted_d;  // words transferred so far
   logic [BIT_W-1:0]    bit_q, bit_d;            // bit index inside current word
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                hold_full_q, hold_full_d;
   logic                underrun_q, underrun_d;
   logic                xfer;
   logic                last_bit;
   logic                clear_frame;
   logic                head_bit;

   // The outgoing bit is always at the end of the shift register that faces
   // the wire, so shifting in zeros from the other end keeps the order right.
   assign head_bit = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];

   always_ff @(posedge clk_1d5M or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, whatever the statement order.
      if (reset) begin
         // NOTE: the data registers are reset too, not only the control state,
         // so a discarded frame can never leak old data into a new one.
         state_q     <= IDLE;
         count_q     <= '0;
         accepted_q  <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         accepted_q  <= accepted_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case statement, so no path
      // leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      count_d     = count_q;
      accepted_d  = accepted_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = 1'b0;
      clear_frame = 1'b0;

      busy       = (state_q != IDLE);
      data_ready = busy && !hold_full_q && (accepted_q < count_q) && (state_q != FINISH);
      dout_en    = (state_q == SHIFT);
      dout       = dout_en & head_bit;
      done       = (state_q == FINISH);
      underrun   = underrun_q;

      xfer     = data_valid && data_ready;
      last_bit = (bit_q == BIT_W'(DATA_W - 1));

      case (state_q)
         IDLE: begin
            if (start && (word_count != '0)) begin
               state_d    = WAIT_FIRST;
               count_d    = word_count;
               accepted_d = '0;
            end
         end
         WAIT_FIRST: begin
            // The first word bypasses the holding register so its first bit
            // leaves on the very next cycle.
            if (xfer) begin
               shift_d    = data_in;
               bit_d      = '0;
               accepted_d = accepted_q + CNT_W'(1);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
            bit_d   = bit_q + BIT_W'(1);
            if (last_bit) begin
               bit_d = '0;
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_d      = '0;
                  hold_full_d = 1'b0;
               end else if (xfer) begin
                  // A word that arrives on the last bit is still in time.
                  shift_d    = data_in;
                  accepted_d = accepted_q + CNT_W'(1);
               end else if (accepted_q == count_q) begin
                  state_d = FINISH;
               end else begin
                  state_d     = IDLE;
                  underrun_d  = 1'b1;
                  clear_frame = 1'b1;
               end
            end else if (xfer) begin
               hold_d      = data_in;
               hold_full_d = 1'b1;
               accepted_d  = accepted_q + CNT_W'(1);
            end
         end
         FINISH: begin
            state_d     = IDLE;
            clear_frame = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            clear_frame = 1'b1;
         end
      endcase

      // Abort overrides everything decided above, including an underrun.
      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         underrun_d  = 1'b0;
         clear_frame = 1'b1;
      end

      if (clear_frame) begin
         count_d     = '0;
         accepted_d  = '0;
         bit_d       = '0;
         shift_d     = '0;
         hold_d      = '0;
         hold_full_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_mvb_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_mvb_frame_serializer
//
// Drives two serializers from the same stimulus, one MSB-first and one
// LSB-first. Accepted words are pushed into per-instance expected-word queues.
// Expected frame endings (done or underrun, with the frame length in bits) are
// pushed into event queues. A monitor per instance pops and compares whenever
// the DUT shows a bit, done or underrun.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mvb_frame_serializer;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 5;
   localparam int NDUT   = 2;   // index 0: MSB first, index 1: LSB first

   typedef enum int {END_DONE, END_UNDER} end_kind_t;
   typedef struct {
      end_kind_t kind;
      int        nbits;
   } end_ev_t;

   logic              clk_1d5M = 1'b0;
   logic              reset    = 1'b1;
   logic              start    = 1'b0;
   logic [CNT_W-1:0]  word_count = '0;
   logic              abort    = 1'b0;
   logic [DATA_W-1:0] data_in  = '0;
   logic              data_valid = 1'b0;
   logic [NDUT-1:0]   data_ready, dout, dout_en, busy, done, underrun;

   int vectors     = 0;
   int miscompares = 0;

   // Feeder state: words still to be offered, with a per-word gap.
   logic [DATA_W-1:0] feed_q[$];
   int                gap_q[$];
   int                gap_cnt      = 0;
   bit                xfer_pending = 1'b0;

   // Scoreboard state, one slot per instance.
   logic [DATA_W-1:0] exp_words[NDUT][$];
   end_ev_t           ev_q[NDUT][$];
   int                run[NDUT];
   int                acc[NDUT];
   int                frame_cnt[NDUT];
   bit                prev_done[NDUT];

   always #5 clk_1d5M = ~clk_1d5M;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mvb_frame_serializer #(
         .DATA_W   (DATA_W),
         .CNT_W    (CNT_W),
         .MSB_FIRST((g == 0) ? 1 : 0)
      ) u_dut (
         .clk_1d5M  (clk_1d5M),
         .reset     (reset),
         .start     (start),
         .word_count(word_count),
         .abort     (abort),
         .data_in   (data_in),
         .data_valid(data_valid),
         .data_ready(data_ready[g]),
         .dout      (dout[g]),
         .dout_en   (dout_en[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .underrun  (underrun[g])
      );

      // Monitor: samples 1 ns after the falling edge, after the drivers.
      always begin : mon
         logic [DATA_W-1:0] w;
         int                p;
         logic              exp_bit;
         end_ev_t           e;
         @(negedge clk_1d5M);
         #1;
         if (dout_en[g]) begin
            if (exp_words[g].size() == 0) begin
               check($sformatf("bit_without_word[%0d]", g), dout_en[g], 0);
            end else begin
               w       = exp_words[g][0];
               p       = run[g] % DATA_W;
               exp_bit = (g == 0) ? w[DATA_W-1-p] : w[p];
               check($sformatf("dout_bit[%0d] run=%0d", g, run[g]), dout[g], exp_bit);
               if (p == DATA_W - 1) void'(exp_words[g].pop_front());
            end
            run[g]++;
         end else begin
            check($sformatf("dout_zero[%0d]", g), dout[g], 0);
            // Inside a frame, once bits have started, a cycle without a bit
            // can only be the completion cycle.
            if (busy[g] && run[g] > 0) check($sformatf("no_gap[%0d]", g), done[g], 1);
         end

         if (done[g]) begin
            check($sformatf("done_busy[%0d]", g), busy[g], 1);
            check($sformatf("done_width[%0d]", g), prev_done[g], 0);
            if (ev_q[g].size() == 0) begin
               check($sformatf("done_unexpected[%0d]", g), done[g], 0);
            end else begin
               e = ev_q[g].pop_front();
               check($sformatf("done_kind[%0d]", g), done[g] ? END_DONE : END_UNDER, e.kind);
               check($sformatf("done_bits[%0d]", g), run[g], e.nbits);
               check($sformatf("done_left[%0d]", g), exp_words[g].size(), 0);
            end
            run[g] = 0;
         end

         if (underrun[g]) begin
            check($sformatf("underrun_busy[%0d]", g), busy[g], 0);
            check($sformatf("underrun_with_done[%0d]", g), done[g], 0);
            if (ev_q[g].size() == 0) begin
               check($sformatf("underrun_unexpected[%0d]", g), underrun[g], 0);
            end else begin
               e = ev_q[g].pop_front();
               check($sformatf("underrun_kind[%0d]", g), underrun[g] ? END_UNDER : END_DONE, e.kind);
               check($sformatf("underrun_bits[%0d]", g), run[g], e.nbits);
               check($sformatf("underrun_left[%0d]", g), exp_words[g].size(), 0);
            end
            run[g] = 0;
         end
         prev_done[g] = done[g];

         // Acceptance rules: never ready when idle, never ready after the
         // frame's last word has been taken.
         if (!busy[g]) check($sformatf("ready_idle[%0d]", g), data_ready[g], 0);
         if (!reset && !busy[g] && start && (word_count != '0)) begin
            frame_cnt[g] = int'(word_count);
            acc[g]       = 0;
         end
         if (busy[g] && acc[g] >= frame_cnt[g])
            check($sformatf("ready_after_last[%0d]", g), data_ready[g], 0);
         if (data_valid && data_ready[g]) acc[g]++;
      end
   end

   // Feeder: offers queued words; gap counts cycles in which data_ready was
   // high before data_valid is raised, so a gap below DATA_W is always in time.
   always @(negedge clk_1d5M) begin
      if (xfer_pending) begin
         xfer_pending = 1'b0;
         data_valid   = 1'b0;
      end
      if (feed_q.size() != 0) begin
         if (!data_valid) begin
            if (gap_cnt >= gap_q[0]) begin
               data_valid = 1'b1;
               data_in    = feed_q[0];
            end else if (data_ready[0]) begin
               gap_cnt++;
            end
         end
         if (data_valid && data_ready[0]) begin
            for (int g = 0; g < NDUT; g++)
               if (data_ready[g]) exp_words[g].push_back(feed_q[0]);
            void'(feed_q.pop_front());
            void'(gap_q.pop_front());
            gap_cnt      = 0;
            xfer_pending = 1'b1;
         end
      end
   end

   task automatic flush();
      feed_q.delete();
      gap_q.delete();
      gap_cnt      = 0;
      xfer_pending = 1'b0;
      data_valid   = 1'b0;
      for (int g = 0; g < NDUT; g++) begin
         exp_words[g].delete();
         run[g] = 0;
      end
   endtask

   task automatic queue_word(input logic [DATA_W-1:0] w, input int gap);
      feed_q.push_back(w);
      gap_q.push_back(gap);
   endtask

   task automatic expect_end(input end_kind_t k, input int nwords);
      end_ev_t e;
      e.kind  = k;
      e.nbits = nwords * DATA_W;
      for (int g = 0; g < NDUT; g++) ev_q[g].push_back(e);
   endtask

   task automatic pulse_start(input int n);
      @(negedge clk_1d5M);
      start      = 1'b1;
      word_count = CNT_W'(n);
      @(negedge clk_1d5M);
      start      = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy != '0 && n < budget) begin
         @(negedge clk_1d5M);
         n++;
      end
      check("frame_timeout", busy, 0);
      if (busy != '0) begin
         abort = 1'b1;
         @(negedge clk_1d5M);
         abort = 1'b0;
         flush();
         for (int g = 0; g < NDUT; g++) ev_q[g].delete();
      end
   endtask

   task automatic random_frame(input int n, input bit starve);
      int k;
      k = starve ? int'($urandom_range(1, n - 1)) : n;
      for (int i = 0; i < k; i++) queue_word(DATA_W'($urandom), int'($urandom_range(0, DATA_W - 1)));
      expect_end(starve ? END_UNDER : END_DONE, k);
      pulse_start(n);
      wait_idle(n * DATA_W * 4 + 100);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;

      // Reset state.
      #12;
      check("reset_busy", busy, 0);
      check("reset_dout_en", dout_en, 0);
      check("reset_dout", dout, 0);
      check("reset_ready", data_ready, 0);
      check("reset_done", done, 0);
      check("reset_underrun", underrun, 0);
      @(negedge clk_1d5M);
      #2 reset = 1'b0;

      // One word 0xA5C3; abort held together with start while idle must not
      // block the frame.
      queue_word(16'hA5C3, 0);
      expect_end(END_DONE, 1);
      @(negedge clk_1d5M);
      start = 1'b1; abort = 1'b1; word_count = CNT_W'(1);
      @(negedge clk_1d5M);
      start = 1'b0; abort = 1'b0;
      wait_idle(200);

      // Three back-to-back words; a second start mid-frame is ignored.
      queue_word(16'h8001, 0);
      queue_word(16'hFFFF, 0);
      queue_word(16'h0000, 0);
      expect_end(END_DONE, 3);
      pulse_start(3);
      repeat (10) @(negedge clk_1d5M);
      start = 1'b1; word_count = CNT_W'(7);
      @(negedge clk_1d5M);
      start = 1'b0;
      wait_idle(400);

      // Single 0x0001: LSB-first instance sends 1 then fifteen zeros.
      queue_word(16'h0001, 3);
      expect_end(END_DONE, 1);
      pulse_start(1);
      wait_idle(200);

      // Second word withheld: underrun, then a normal frame afterwards.
      queue_word(16'h1234, 0);
      expect_end(END_UNDER, 1);
      pulse_start(2);
      wait_idle(400);
      random_frame(2, 1'b0);

      // Last-moment word (gap DATA_W-1) on every word.
      for (int i = 0; i < 4; i++) queue_word(DATA_W'($urandom), DATA_W - 1);
      expect_end(END_DONE, 4);
      pulse_start(4);
      wait_idle(600);

      // Abort at bit 7 of word 2 of 4.
      for (int i = 0; i < 4; i++) queue_word(DATA_W'($urandom), int'($urandom_range(0, DATA_W - 1)));
      pulse_start(4);
      n = 0;
      while (dout_en[0] == 1'b0 && n < 100) begin
         @(negedge clk_1d5M);
         n++;
      end
      check("abort_frame_running", dout_en, 2'b11);
      repeat (DATA_W + 7) @(negedge clk_1d5M);
      abort = 1'b1;
      @(negedge clk_1d5M);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_dout_en", dout_en, 0);
      check("abort_dout", dout, 0);
      check("abort_ready", data_ready, 0);
      check("abort_done", done, 0);
      check("abort_underrun", underrun, 0);
      flush();

      // word_count = 0 is ignored.
      @(negedge clk_1d5M);
      start = 1'b1; word_count = '0;
      repeat (3) begin
         @(negedge clk_1d5M);
         check("zero_count_busy", busy, 0);
      end
      start = 1'b0;

      // Asynchronous reset between clock edges mid-frame.
      for (int i = 0; i < 3; i++) queue_word(DATA_W'($urandom), int'($urandom_range(0, 4)));
      pulse_start(3);
      repeat (20) @(negedge clk_1d5M);
      check("busy_before_reset", busy, 2'b11);
      #2 reset = 1'b1;
      #1;
      check("async_reset_busy", busy, 0);
      check("async_reset_dout_en", dout_en, 0);
      check("async_reset_dout", dout, 0);
      check("async_reset_ready", data_ready, 0);
      check("async_reset_done", done, 0);
      check("async_reset_underrun", underrun, 0);
      @(negedge clk_1d5M);
      flush();
      #2 reset = 1'b0;

      // data_valid without start: nothing is accepted.
      @(negedge clk_1d5M);
      data_valid = 1'b1; data_in = DATA_W'($urandom);
      repeat (10) begin
         @(negedge clk_1d5M);
         check("no_start_ready", data_ready, 0);
         check("no_start_busy", busy, 0);
      end
      data_valid = 1'b0;

      // Largest frame the count field allows.
      for (int i = 0; i < 31; i++) queue_word(DATA_W'($urandom), 0);
      expect_end(END_DONE, 31);
      pulse_start(31);
      wait_idle(31 * DATA_W + 100);

      // Randomised frames, some starved.
      for (int f = 0; f < 30; f++) begin
         n = int'($urandom_range(1, 6));
         random_frame(n, (n > 1) && ($urandom_range(0, 4) == 0));
      end

      repeat (3) @(negedge clk_1d5M);
      for (int g = 0; g < NDUT; g++) begin
         check($sformatf("pending_events[%0d]", g), ev_q[g].size(), 0);
         check($sformatf("pending_words[%0d]", g), exp_words[g].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mvb_frame_serializer.md
MVB_FRAME_SERIALIZER -- requirements
Module: mvb_frame_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the bits per word.
REQ-002 SHALL have parameter CNT_W, default 5, meaning the width of the word-count field.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning MSB-first shifting when 1 and LSB-first when 0.
REQ-004 SHALL have port clk_1d5M, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: frame start request, sampled only in IDLE.
REQ-007 SHALL have port word_count, input, CNT_W bits: words in the frame, sampled with start.
REQ-008 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-009 SHALL have port data_in, input, DATA_W bits: parallel word.
REQ-010 SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-011 SHALL have port data_ready, output, 1 bit: block accepts data_in this cycle.
REQ-012 SHALL have port dout, output, 1 bit: serial bit.
REQ-013 SHALL have port dout_en, output, 1 bit: dout carries a frame bit.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on frame completion.
REQ-016 SHALL have port underrun, output, 1 bit: one-cycle pulse on frame abort caused by data starvation.

Function
REQ-017 SHALL implement states IDLE, WAIT_FIRST, SHIFT and FINISH, plus a one-word holding register in front of the shift register.
REQ-018 IDLE: start=1 with word_count!=0 SHALL latch word_count, set busy=1 next cycle and go to WAIT_FIRST; word_count=0 SHALL ignore start.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 data_ready SHALL be 1 iff busy=1, the holding register is empty, words_accepted<word_count and state is not FINISH; a word transfers only when data_valid=1 and data_ready=1.
REQ-021 WAIT_FIRST SHALL wait indefinitely; on transfer the word loads directly into the shift register and goes to SHIFT.
REQ-022 SHALL drive the first bit (data_in[DATA_W-1] if MSB_FIRST, else data_in[0]) with dout_en=1 in the cycle after the transfer.
REQ-023 Each word SHALL occupy exactly DATA_W consecutive cycles, one bit per cycle, in parameter order.
REQ-024 A word transferred during SHIFT SHALL go to the holding register.
REQ-025 At a word's last-bit cycle with the holding register full, the held word SHALL move to the shift register, with its first bit on the next cycle and no gap.
REQ-026 At a word's last-bit cycle with the holding register empty and words remaining, the block SHALL pulse underrun=1 next cycle, return to IDLE, clear both registers, and not pulse done.
REQ-027 A transfer in the same cycle as a last bit SHALL count as held in time, with no underrun.
REQ-028 After the last bit of word word_count, the block SHALL enter FINISH for one cycle with done=1, busy=1 and dout_en=0, then go to IDLE with busy=0.
REQ-029 Whenever dout_en=0, dout SHALL be 0.
REQ-030 abort=1 in any non-IDLE state SHALL, on the next cycle, give busy=0, dout=0, dout_en=0 and data_ready=0, clear the registers and counters, and give no done or underrun pulse.
REQ-031 abort SHALL take priority over every other event in the same cycle.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 The word and bit counters SHALL be wide enough for 2^CNT_W-1 words and DATA_W bits, and SHALL never wrap within a frame.

Reset
REQ-034 reset=1 SHALL asynchronously force IDLE and drive dout, dout_en, data_ready, busy, done and underrun to 0, and SHALL clear the holding register, shift register and all counters.
REQ-035 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL require a new start.

Verification
REQ-036 Case 1: start, word_count=1, word 0xA5C3, MSB_FIRST=1 -> dout_en high for 16 cycles, dout = 1010010111000011, then done for 1 cycle.
REQ-037 Case 2: word_count=3, words 0x8001, 0xFFFF, 0x0000, data_valid held high -> 48 contiguous dout_en cycles with no gaps, then done; data_ready never high after the 3rd transfer.
REQ-038 Case 3: MSB_FIRST=0, word 0x0001 -> first dout bit 1, then 15 zeros.
REQ-039 Case 4: word_count=2, second word withheld past the first word's 16th bit -> underrun pulse, busy=0, no done; a later start works normally.
REQ-040 Case 5: abort at bit 7 of word 2 of 4 -> busy=0 and dout_en=0 next cycle, no done, no underrun; start with word_count=0 -> busy stays 0.
REQ-041 Case 6: reset pulsed asynchronously between clock edges mid-frame -> all outputs 0 immediately; data_valid with no start -> data_ready stays 0.
